// File: rtl/serial_digit_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// The state enum and sizing functions are used by the top level.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter to keep widths legal.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple slice built from full adders.
// Cmsb exposes the carry into the top bit so the caller can form signed overflow.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin,
  output logic [DIGIT-1:0] S,
  output logic             Co,
  output logic             Cmsb
);
  logic [DIGIT:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fulladder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  assign Co   = c[DIGIT];
  assign Cmsb = c[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT-wide slice per clock through a registered carry,
// with valid/ready handshakes on both operand and result sides.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(NDIG);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] s_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .A    (a_q[DIGIT-1:0]),
    .B    (b_q[DIGIT-1:0]),
    .Cin  (carry_q),
    .S    (dig_sum),
    .Co   (dig_co),
    .Cmsb (dig_cmsb)
  );

  // New digits enter at the top so after NDIG steps digit 0 sits at the bottom.
  if (NDIG == 1) begin : g_one_digit
    assign s_shift = dig_sum;
  end else begin : g_multi_digit
    assign s_shift = {dig_sum, s_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = s_shift;
        carry_d = dig_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_DIG) begin
          co_d    = dig_co;
          ov_d    = dig_cmsb ^ dig_co;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign S         = s_q;
  assign Co        = co_q;
  assign Ov        = ov_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench: three configurations (16/4, 4/1, 8/8) checked against an arithmetic
// reference model, covering directed cases, backpressure, async reset and random traffic.
module tb_serial_digit_adder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_s;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        cin_s;
  logic        out_ready_s;

  logic [2:0]  in_ready_s;
  logic [2:0]  out_valid_s;
  logic [2:0]  co_s;
  logic [2:0]  ov_s;
  logic [15:0] s0_s;
  logic [3:0]  s1_s;
  logic [7:0]  s2_s;

  int errors = 0;
  int checks = 0;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .A(a_s), .B(b_s), .Cin(cin_s), .out_valid(out_valid_s[0]), .out_ready(out_ready_s),
    .S(s0_s), .Co(co_s[0]), .Ov(ov_s[0])
  );

  serial_digit_adder #(.WIDTH(4), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .A(a_s[3:0]), .B(b_s[3:0]), .Cin(cin_s), .out_valid(out_valid_s[1]), .out_ready(out_ready_s),
    .S(s1_s), .Co(co_s[1]), .Ov(ov_s[1])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .A(a_s[7:0]), .B(b_s[7:0]), .Cin(cin_s), .out_valid(out_valid_s[2]), .out_ready(out_ready_s),
    .S(s2_s), .Co(co_s[2]), .Ov(ov_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      1:       return 4;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int ndig_of(input int sel);
    case (sel)
      1:       return 4;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] get_s(input int sel);
    case (sel)
      1:       return {12'd0, s1_s};
      2:       return {8'd0, s2_s};
      default: return s0_s;
    endcase
  endfunction

  // Reference: plain integer addition, result {ov, co, s}.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    int unsigned m, sum, s, co, sa, sb, ss, ov;
    m   = (32'd1 << w) - 32'd1;
    sum = (32'(a) & m) + (32'(b) & m) + 32'(cin);
    s   = sum & m;
    co  = (sum >> w) & 32'd1;
    sa  = (32'(a) >> (w - 1)) & 32'd1;
    sb  = (32'(b) >> (w - 1)) & 32'd1;
    ss  = (s >> (w - 1)) & 32'd1;
    ov  = ((sa == sb) && (ss != sa)) ? 32'd1 : 32'd0;
    return {ov[0], co[0], s[15:0]};
  endfunction

  task automatic wait_ready(input int sel, input string tag);
    int g = 0;
    while (!in_ready_s[sel] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "/ready"}, 32'(in_ready_s[sel]), 32'd1);
  endtask

  // One full transaction on DUT 'sel' with latency, result and handshake checks.
  task automatic run_add(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input string tag);
    logic [17:0] e;
    int lat;
    e = ref_add(width_of(sel), a, b, cin);
    wait_ready(sel, tag);
    a_s = a;
    b_s = b;
    cin_s = cin;
    in_valid_s[sel] = 1'b1;
    @(negedge clk);
    in_valid_s[sel] = 1'b0;
    a_s = 16'hDEAD;
    b_s = 16'hBEEF;
    lat = 0;
    while (!out_valid_s[sel] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(ndig_of(sel)));
    check({tag, "/S"}, 32'(get_s(sel)), 32'(e[15:0]));
    check({tag, "/Co"}, 32'(co_s[sel]), 32'(e[16]));
    check({tag, "/Ov"}, 32'(ov_s[sel]), 32'(e[17]));
    out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;
    check({tag, "/valid_drop"}, 32'(out_valid_s[sel]), 32'd0);
    check({tag, "/ready_back"}, 32'(in_ready_s[sel]), 32'd1);
  endtask

  task automatic backpressure_test();
    logic [17:0] e;
    int g;
    e = ref_add(16, 16'h1111, 16'h2222, 1'b0);
    wait_ready(0, "bp");
    a_s = 16'h1111;
    b_s = 16'h2222;
    cin_s = 1'b0;
    in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    g = 0;
    while (!out_valid_s[0] && g < 64) begin
      @(negedge clk);
      g++;
    end
    check("bp/reach_done", 32'(out_valid_s[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a_s = 16'($urandom);
      b_s = 16'($urandom);
      cin_s = 1'($urandom);
      in_valid_s[0] = 1'b1;
      @(negedge clk);
      check("bp/S_hold", 32'(s0_s), 32'(e[15:0]));
      check("bp/Co_hold", 32'(co_s[0]), 32'(e[16]));
      check("bp/Ov_hold", 32'(ov_s[0]), 32'(e[17]));
      check("bp/in_ready_low", 32'(in_ready_s[0]), 32'd0);
      check("bp/out_valid_hold", 32'(out_valid_s[0]), 32'd1);
    end
    in_valid_s[0] = 1'b0;
    out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;
    check("bp/in_ready_after", 32'(in_ready_s[0]), 32'd1);
    run_add(0, 16'h0F0F, 16'h00F1, 1'b1, "bp_next");
  endtask

  task automatic reset_mid_run_test();
    wait_ready(0, "rst");
    a_s = 16'hAAAA;
    b_s = 16'h5555;
    cin_s = 1'b1;
    in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst/out_valid", 32'(out_valid_s[0]), 32'd0);
    check("rst/S", 32'(s0_s), 32'd0);
    check("rst/in_ready", 32'(in_ready_s[0]), 32'd1);
    check("rst/Co", 32'(co_s[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_add(0, 16'h00FF, 16'h0001, 1'b0, "after_rst");
  endtask

  // Random valid/ready traffic on the 16/4 instance with an in-order scoreboard.
  task automatic random_traffic(input int ntx);
    logic [17:0] exp_q[$];
    logic [17:0] e;
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    logic ir_last = 1'b0;
    logic dup_seen = 1'b0;
    while (rcvd < ntx && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (in_valid_s[0] && ir_last) begin
        in_valid_s[0] = 1'b0;
      end
      if (!in_valid_s[0] && sent < ntx && ($urandom_range(2) != 0)) begin
        a_s = 16'($urandom);
        b_s = 16'($urandom);
        cin_s = 1'($urandom);
        exp_q.push_back(ref_add(16, a_s, b_s, cin_s));
        in_valid_s[0] = 1'b1;
        sent++;
      end
      ir_last = in_ready_s[0];
      out_ready_s = ($urandom_range(3) != 0);
      if (out_valid_s[0] && out_ready_s) begin
        if (exp_q.size() == 0) begin
          dup_seen = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("rnd/S", 32'(s0_s), 32'(e[15:0]));
          check("rnd/Co", 32'(co_s[0]), 32'(e[16]));
          check("rnd/Ov", 32'(ov_s[0]), 32'(e[17]));
        end
        rcvd++;
      end
    end
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    out_ready_s = 1'b0;
    check("rnd/received", 32'(rcvd), 32'(ntx));
    check("rnd/no_extra", 32'(dup_seen), 32'd0);
    check("rnd/queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_s = 3'b000;
    a_s = 16'd0;
    b_s = 16'd0;
    cin_s = 1'b0;
    out_ready_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/in_ready", 32'(in_ready_s), 32'h7);
    check("reset/out_valid", 32'(out_valid_s), 32'h0);
    check("reset/S", 32'(s0_s), 32'h0);
    check("reset/CoOv", 32'({co_s[0], ov_s[0]}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle/in_ready", 32'(in_ready_s[0]), 32'd1);

    run_add(0, 16'hFFFF, 16'h0001, 1'b0, "ffff+1");
    run_add(0, 16'h7FFF, 16'h0001, 1'b0, "7fff+1");
    run_add(0, 16'h1234, 16'h4321, 1'b1, "1234+4321+1");
    run_add(0, 16'h8000, 16'h8000, 1'b0, "8000+8000");
    run_add(0, 16'hFFFF, 16'hFFFF, 1'b1, "ffff+ffff+1");

    backpressure_test();
    reset_mid_run_test();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          run_add(1, 16'(a), 16'(b), 1'(c), "w4d1");
        end
      end
    end

    run_add(2, 16'h0080, 16'h0080, 1'b0, "w8d8_80+80");
    for (int i = 0; i < 20; i++) begin
      run_add(2, 16'($urandom_range(255)), 16'($urandom_range(255)), 1'($urandom), "w8d8_rnd");
    end

    random_traffic(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Parametrised, multi-cycle successor to the 4-bit ripple-carry adder. Adds two WIDTH-bit operands plus carry-in by processing DIGIT bits per clock through a registered carry, so a wide add runs on a narrow ripple slice. Operands enter and results leave through valid/ready handshakes. Sits between operand producers and result consumers wherever area matters more than single-cycle latency.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT (elaboration error otherwise)
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands A, B, Cin valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  addend
- B  input  WIDTH  addend
- Cin  input  1  carry-in to bit 0
- out_valid  output  1  S, Co, Ov valid
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum, A+B+Cin modulo 2^WIDTH
- Co  output  1  carry out of bit WIDTH-1 (unsigned overflow)
- Ov  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- NDIG = WIDTH/DIGIT digits; digit 0 = bits DIGIT-1:0, processed first.
- FSM states IDLE, RUN, DONE; reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture A, B into shift registers, Cin into carry register, clear digit counter, go RUN.
- RUN: each cycle add low digit of A and B plus carry register; store digit sum into result register (shift in from the top), update carry register, shift A/B right by DIGIT, increment counter. After digit NDIG-1, record Co and Ov, go DONE.
- DONE: out_valid=1; S, Co, Ov held stable. On out_ready, go IDLE.
- in_ready=0 in RUN and DONE; in_valid ignored there; A/B/Cin changes ignored after capture.
- Arithmetic: unsigned modulo 2^WIDTH; Co and Ov reported per Interface; no saturation.
- Reset (any state, including mid-RUN or DONE): state IDLE, in_ready=1, out_valid=0, S=0, Co=0, Ov=0, carry/counter/shift registers cleared; partial operation discarded, nothing emitted.

## Timing
- Acceptance on rising edge t0. Digits processed on edges t1..tNDIG. out_valid high from after tNDIG. Latency = NDIG cycles from accepting edge to out_valid.
- With out_ready held high: result transferred on edge tNDIG+1, in_ready high after it; next accept earliest at tNDIG+2. Throughput one add per NDIG+2 cycles.
- in_ready and out_valid decode from registered state only: no combinational path from in_valid or out_ready.
- NDIG=1 (DIGIT=WIDTH): single RUN cycle, latency 1.
- out_ready high while out_valid=0: no effect.

## Structure
- Shared package: FSM state enum (IDLE, RUN, DONE); localparam function for NDIG and counter width ($clog2(NDIG), minimum 1).
- One sub-module: digit_adder, a combinational DIGIT-bit ripple slice of fulladder instances (ports A, B, Cin, S, Co, plus Cmsb = carry into top bit for Ov). Top level holds the FSM, shift/result registers and carry register.

## Test plan
- WIDTH=16, DIGIT=4: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Co=1, Ov=0; out_valid exactly 4 cycles after the accepting edge.
- A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Co=0, Ov=1; A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Co=0, Ov=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> S/Co/Ov stable, in_ready=0, new operands not captured; after out_ready=1, in_ready=1 the next cycle and next add correct.
- Reset mid-RUN: assert rst_n=0 after 2 digits -> out_valid=0, S=0, in_ready=1 immediately (asynchronously); next add A=0x00FF, B=0x0001 -> S=0x0100.
- Parameter sweep: WIDTH=4, DIGIT=1 exhaustive over all A, B, Cin (512 cases) vs reference A+B+Cin, latency 4; WIDTH=8, DIGIT=8: A=0x80, B=0x80 -> S=0x00, Co=1, Ov=1, latency 1.
- Back-to-back random: 1000 transactions, random in_valid/out_ready gaps, scoreboard checks S, Co, Ov and no lost or duplicated results.
